// File: rtl/store_pack.sv
// Store buffer: packs byte/half/word stores into word-aligned writes.
// Ports: req_* pipeline side, mem_* memory side, ades/ades_badvaddr
// misaligned-store fault, buf_empty. Optional STORE_MISALIGN_EXC_EN.
module store_pack #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        ades,
  output logic [31:0] ades_badvaddr,
  output logic        buf_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [29:0] a_mem [DEPTH];
  logic [31:0] d_mem [DEPTH];
  logic [3:0]  s_mem [DEPTH];

  logic [PW-1:0] wp, rp;
  logic [PW:0]   count;

  logic        acc, push, pop, mis;
  logic [31:0] pk_data;
  logic [3:0]  pk_strb;
  logic        is_b, is_h;

  assign is_b = (req_size == 2'b00);
  assign is_h = (req_size == 2'b01);

  always_comb begin
    pk_data = req_data;
    pk_strb = 4'b1111;
    unique case (1'b1)
      is_b: begin
        pk_data = {4{req_data[7:0]}};
        pk_strb = 4'b0001 << req_addr[1:0];
      end
      is_h: begin
        pk_data = {2{req_data[15:0]}};
        pk_strb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        pk_data = req_data;
        pk_strb = 4'b1111;
      end
    endcase
  end

  assign req_ready = (count < (PW+1)'(DEPTH));
  assign mem_valid = (count != '0);
  assign buf_empty = (count == '0);
  assign acc = req_valid && req_ready;
  assign pop = mem_valid && mem_ready;

  // Payload is gated so it reads as zero whenever nothing is pending,
  // which also covers the reset state.
  assign mem_addr  = mem_valid ? {a_mem[rp], 2'b00} : '0;
  assign mem_wdata = mem_valid ? d_mem[rp] : '0;
  assign mem_wstrb = mem_valid ? s_mem[rp] : '0;

`ifdef STORE_MISALIGN_EXC_EN
  assign mis = (is_h && req_addr[0]) ||
               (req_size[1] && (req_addr[1:0] != 2'b00));
  assign push = acc && !mis;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ades          <= 1'b0;
      ades_badvaddr <= '0;
    end else begin
      ades <= acc && mis;
      if (acc && mis)
        ades_badvaddr <= req_addr;
    end
  end
`else
  assign mis  = 1'b0;
  assign push = acc && !mis;
  assign ades          = 1'b0;
  assign ades_badvaddr = '0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wp] <= req_addr[31:2];
      d_mem[wp] <= pk_data;
      s_mem[wp] <= pk_strb;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/store_pack.md
STORE_PACK -- requirements
Module: store_pack

Interface
REQ-001 SHALL have parameter: DEPTH, default 2, store-buffer entries (power of 2, >=2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  store request from pipeline.
REQ-005 SHALL have port: req_ready  output  1  buffer can accept request.
REQ-006 SHALL have port: req_addr  input  32  byte address of store.
REQ-007 SHALL have port: req_data  input  32  register data, value in low bits.
REQ-008 SHALL have port: req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port: mem_valid  output  1  write request to data memory.
REQ-010 SHALL have port: mem_ready  input  1  memory accepts write.
REQ-011 SHALL have port: mem_addr  output  32  word-aligned address, bits[1:0]=00.
REQ-012 SHALL have port: mem_wdata  output  32  packed write data.
REQ-013 SHALL have port: mem_wstrb  output  4  byte write enables.
REQ-014 SHALL have port: ades  output  1  one-cycle misaligned-store exception pulse.
REQ-015 SHALL have port: ades_badvaddr  output  32  faulting address, held until next fault.
REQ-016 SHALL have port: buf_empty  output  1  no stores pending (for sync/uncached ordering).

Function
REQ-017 SHALL accept a request on cycle where req_valid && req_ready; req_ready = (count < DEPTH), with no same-cycle pass-through when full.
REQ-018 SHALL pack byte stores: wdata = {4{req_data[7:0]}}, wstrb = 0001 << addr[1:0].
REQ-019 SHALL pack half stores: wdata = {2{req_data[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
REQ-020 SHALL pack word stores: wdata = req_data, wstrb = 1111.
REQ-021 SHALL enqueue packed {addr[31:2],00, wdata, wstrb} in FIFO order; earliest mem_valid is the cycle after acceptance (1-cycle latency).
REQ-022 SHALL assert mem_valid whenever FIFO is non-empty, presenting the head entry; payload SHALL stay stable until mem_valid && mem_ready.
REQ-023 SHALL pop the head on mem_valid && mem_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; count SHALL range 0..DEPTH with no overflow or underflow.
REQ-025 SHALL drive buf_empty = (count == 0), registered state only.
REQ-026 SHALL never drop or reorder an accepted, aligned store.

Reset
REQ-027 SHALL, on resetn low, asynchronously clear pointers and count; mem_valid=0, ades=0, ades_badvaddr=0, buf_empty=1, req_ready=1.
REQ-028 SHALL discard pending entries on reset mid-operation; mem_valid SHALL drop immediately, even during an unacknowledged write.
REQ-029 SHALL hold mem_addr/mem_wdata/mem_wstrb at 0 while in reset.

Configuration
REQ-030 SHALL support macro STORE_MISALIGN_EXC_EN.
REQ-031 SHALL, with STORE_MISALIGN_EXC_EN defined, treat half with addr[0]=1 or word with addr[1:0]!=00 as misaligned: handshake completes, nothing enqueued, ades pulses high exactly one cycle later, ades_badvaddr latches req_addr.
REQ-032 SHALL, without STORE_MISALIGN_EXC_EN, ignore addr[0] for half and addr[1:0] for word (forced alignment), enqueue normally, and tie ades and ades_badvaddr to 0.

Verification
REQ-033 SHALL cover: sb addr=0x1003 data=0x000000AB -> next cycle mem_addr=0x1000, wdata=0xABABABAB, wstrb=1000.
REQ-034 SHALL cover: sh addr=0x2002 data=0x1234BEEF -> mem_addr=0x2000, wdata=0xBEEFBEEF, wstrb=1100.
REQ-035 SHALL cover: mem_ready=0, three sw pushes with DEPTH=2 -> third stalls with req_ready=0; release mem_ready -> writes drain in order, buf_empty=1 after last.
REQ-036 SHALL cover: full buffer, mem_ready=1 and req_valid=1 same cycle -> pop that cycle, req_ready=1 next cycle, count back to 2 after push, order preserved.
REQ-037 SHALL cover: with STORE_MISALIGN_EXC_EN, sw addr=0x3001 -> ades=1 one cycle, ades_badvaddr=0x3001, mem_valid stays 0; without macro -> mem_addr=0x3000, wstrb=1111, ades=0.
REQ-038 SHALL cover: resetn low while mem_valid=1 and mem_ready=0 with 2 entries -> mem_valid=0 immediately, buf_empty=1, req_ready=1.
